// File: rtl/elevator_call_scheduler_if.sv
// Call-scheduler port bundle: call buttons and controller handshake toward the
// scheduler, target floor and status back out.
interface elevator_call_scheduler_if #(
    parameter int NUM_FLOORS = 6,
    parameter int FLOOR_W    = 3
);
    logic [NUM_FLOORS-1:0] req;
    logic                  finish;
    logic [FLOOR_W-1:0]    dest_floor;
    logic                  door_open;
    logic                  moving;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output req, finish,
        input  dest_floor, door_open, moving, dir_up, pending
    );

    modport slave (
        input  req, finish,
        output dest_floor, door_open, moving, dir_up, pending
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls, picks the next stop with a SCAN (direction-preferring)
// policy, hands it to the elevator controller and holds the door for a fixed dwell.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS  = 6,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    elevator_call_scheduler_if.slave      bus
);
    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [FLOOR_W-1:0]    cur_floor_r, cur_nxt_s;
    logic [FLOOR_W-1:0]    dest_floor_r, dest_nxt_s;
    logic                  dir_up_r, dir_nxt_s;
    logic [CNT_W-1:0]      door_cnt_r, cnt_nxt_s;
    logic [NUM_FLOORS-1:0] pending_r, clear_mask_s;
    logic                  door_open_r, moving_r;
    logic                  above_found_s, below_found_s;
    logic [FLOOR_W-1:0]    above_idx_s, below_idx_s;

    // Nearest pending floor on each side of the car; only floors 0..NUM_FLOORS-1 can hit.
    always_comb begin
        above_found_s = 1'b0;
        above_idx_s   = cur_floor_r;
        below_found_s = 1'b0;
        below_idx_s   = cur_floor_r;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            above_found_s = above_found_s | (pending_r[i] & (FLOOR_W'(i) > cur_floor_r));
            above_idx_s   = (pending_r[i] && (FLOOR_W'(i) > cur_floor_r)) ? FLOOR_W'(i) : above_idx_s;
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            below_found_s = below_found_s | (pending_r[i] & (FLOOR_W'(i) < cur_floor_r));
            below_idx_s   = (pending_r[i] && (FLOOR_W'(i) < cur_floor_r)) ? FLOOR_W'(i) : below_idx_s;
        end
    end

    // Next-state logic, stop selection and the per-cycle clear mask for pending calls.
    always_comb begin
        state_nxt_s  = state_r;
        cur_nxt_s    = cur_floor_r;
        dest_nxt_s   = dest_floor_r;
        dir_nxt_s    = dir_up_r;
        cnt_nxt_s    = door_cnt_r;
        clear_mask_s = {NUM_FLOORS{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pending_r[cur_floor_r]) begin
                    clear_mask_s[cur_floor_r] = 1'b1;
                    cnt_nxt_s                 = CNT_LOAD;
                    state_nxt_s               = ST_DOOR;
                end else if (|pending_r) begin
                    state_nxt_s = ST_MOVE;
                    if (dir_up_r) begin
                        if (above_found_s) begin
                            dest_nxt_s = above_idx_s;
                        end else begin
                            dest_nxt_s = below_idx_s;
                            dir_nxt_s  = 1'b0;
                        end
                    end else begin
                        if (below_found_s) begin
                            dest_nxt_s = below_idx_s;
                        end else begin
                            dest_nxt_s = above_idx_s;
                            dir_nxt_s  = 1'b1;
                        end
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (bus.finish) begin
                    cur_nxt_s                  = dest_floor_r;
                    clear_mask_s[dest_floor_r] = 1'b1;
                    cnt_nxt_s                  = CNT_LOAD;
                    state_nxt_s                = ST_DOOR;
                end else begin
                    state_nxt_s = ST_MOVE;
                end
            end
            ST_DOOR: begin
                // A call for the floor the door is already open at just extends the dwell.
                if (bus.req[cur_floor_r]) begin
                    clear_mask_s[cur_floor_r] = 1'b1;
                    cnt_nxt_s                 = CNT_LOAD;
                end else if (door_cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = door_cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, call latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cur_floor_r  <= {FLOOR_W{1'b0}};
            dest_floor_r <= {FLOOR_W{1'b0}};
            dir_up_r     <= 1'b1;
            door_cnt_r   <= {CNT_W{1'b0}};
            pending_r    <= {NUM_FLOORS{1'b0}};
            door_open_r  <= 1'b0;
            moving_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cur_floor_r  <= cur_nxt_s;
            dest_floor_r <= dest_nxt_s;
            dir_up_r     <= dir_nxt_s;
            door_cnt_r   <= cnt_nxt_s;
            pending_r    <= (pending_r | bus.req) & ~clear_mask_s;
            door_open_r  <= (state_nxt_s == ST_DOOR);
            moving_r     <= (state_nxt_s == ST_MOVE);
        end
    end

    assign bus.dest_floor = dest_floor_r;
    assign bus.door_open  = door_open_r;
    assign bus.moving     = moving_r;
    assign bus.dir_up     = dir_up_r;
    assign bus.pending    = pending_r;
endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Request-side front end for the elevator controller. Latches floor call buttons and picks the next stop with a direction-preferring (SCAN) policy. Drives the controller's `dest_floor` input and consumes its `finish` output, then holds the door open for a fixed dwell before serving the next call. It sits between the call-button inputs and the elevator controller, and shares that controller's clock and reset.

## Interface
- `NUM_FLOORS`, default 6: number of served floors, numbered 0..NUM_FLOORS-1.
- `FLOOR_W`, default 3: floor index width; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- `DOOR_CYCLES`, default 20: door-open dwell in clock cycles; must be >= 1.

One clock; reset is synchronous and active-high.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_FLOORS  call request per floor. Each bit is level or pulse and is latched on any cycle it is high.
- `finish`  in  1  from the controller: high when the car is at `dest_floor`.
- `dest_floor`  out  FLOOR_W  registered target floor, sent to the controller.
- `door_open`  out  1  high while in DOOR.
- `moving`  out  1  high while in MOVE.
- `dir_up`  out  1  current sweep direction: 1 = up, 0 = down.
- `pending`  out  NUM_FLOORS  latched, unserved calls.

## Operation
- Internal registers:
  - `cur_floor` (FLOOR_W): last floor the car stopped at.
  - `door_cnt`: wide enough to hold DOOR_CYCLES-1.
- States: IDLE, MOVE, DOOR.
- Reset values:
  - state = IDLE.
  - `dest_floor` = 0, `cur_floor` = 0.
  - `pending` = 0, `door_open` = 0, `moving` = 0.
  - `dir_up` = 1, `door_cnt` = 0.
- Latching: every cycle, `pending <= (pending | req) & ~clear_mask`. Clear wins when a set and a clear hit the same bit in the same cycle.
- IDLE:
  - `dest_floor` equals `cur_floor`.
  - If `pending[cur_floor]` is set: clear that bit, load `door_cnt` = DOOR_CYCLES-1, go to DOOR.
  - Else, if `pending` is nonzero, select a target (rule below), register it into `dest_floor`, and go to MOVE.
  - Else stay in IDLE.
- Target selection:
  - With `dir_up` = 1: take the lowest pending floor above `cur_floor`. If there is none, take the highest pending floor below `cur_floor` and set `dir_up` = 0.
  - With `dir_up` = 0: take the highest pending floor below `cur_floor`. If there is none, take the lowest pending floor above `cur_floor` and set `dir_up` = 1.
- MOVE:
  - `dest_floor` is frozen; there is no retargeting while moving.
  - New `req` bits are only latched.
  - When `finish` = 1: set `cur_floor <= dest_floor`, clear `pending[dest_floor]`, load `door_cnt` = DOOR_CYCLES-1, go to DOOR.
- DOOR:
  - `door_open` = 1.
  - A `req` for `cur_floor` is absorbed: the bit is not latched and `door_cnt` is reloaded to DOOR_CYCLES-1, extending the dwell.
  - Otherwise decrement `door_cnt`. At 0, go to IDLE.
- Out-of-range bits: `req` bits at or above NUM_FLOORS do not exist at the port. If FLOOR_W allows indices ≥ NUM_FLOORS, those values are never issued on `dest_floor`.
- Reset mid-operation: everything returns to reset values and any latched calls are lost. The controller resets on the same `rst`, so both sides agree on floor 0.

## Timing
- `req` high in cycle t → `pending` bit visible in cycle t+1.
- IDLE with a nonzero `pending` in cycle t → `dest_floor` and `moving` update at the edge ending cycle t. There is one cycle of decision latency.
- `finish` is sampled by the registered state. In the first MOVE cycle the controller already sees the new `dest_floor`, and `finish` is 0 because target ≠ `cur_floor`.
- `finish` = 1 in cycle t (MOVE) → `door_open` = 1 from t+1 through t+DOOR_CYCLES, then IDLE at t+DOOR_CYCLES+1 (absent extensions).
- Controller travel time is 11 cycles per floor. The scheduler imposes no timeout.
- Minimum spacing between consecutive stops is DOOR_CYCLES+1 cycles plus travel time.

## Test plan
- Reset, then `req[3]` pulsed for 1 cycle:
  - `pending` = 6'b001000 next cycle.
  - `dest_floor` = 3 and `moving` = 1 one cycle later.
  - `door_open` for exactly 20 cycles after arrival (~33 cycles of travel).
  - Ends with `pending` = 0, `cur_floor` = 3.
- Car idle at floor 3 with `dir_up` = 1; `req[1]` and `req[5]` set simultaneously:
  - Serves 5 first, then 1.
  - `dir_up` = 0 when floor 1 is selected.
- Car idle at floor 2; `req[2]` pulsed:
  - Goes straight to DOOR with no MOVE.
  - `dest_floor` stays 2.
- During DOOR at floor 4, `req[4]` pulsed with `door_cnt` = 5:
  - Counter reloads to 19.
  - `pending[4]` stays 0; total dwell is extended.
- During MOVE toward 5, `req[2]` is asserted and the car passes floor 2:
  - No stop at 2; `dest_floor` stays 5.
  - Floor 2 is served after the door dwell at 5.
- `rst` asserted mid-MOVE with `pending` = 6'b100110:
  - Next cycle all outputs are at reset values.
  - Scheduler is in IDLE with `dest_floor` = 0 and `pending` = 0.
